// File: rtl/act_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : act_pkg
//  Description : Shared types, constants and helpers for activation_arbiter
//                and its sub-blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package act_pkg;

    // Width of every statistics counter (stall and per-lane grant counters)
    localparam int ACT_STAT_W = 32;

    // Output register state: empty or holding one result
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // ceil(log2(n)) but never below 1, so an index of a 2-entry set still
    // gets a 1-bit field and the tag port is never zero width
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/activation_sigmoid.sv
`default_nettype none
// ============================================================================
//  Module      : activation_sigmoid
//  Description : Combinational 256-entry sigmoid lookup. Input is signed
//                Q(WIDTH-FRAC_BITS).FRAC_BITS, output unsigned with
//                FRAC_BITS fractional bits. The input range [-8, 8) is cut
//                into 256 equal bins; entry i holds sigmoid(-8 + 16*i/255)
//                so the end entries land exactly on sigmoid(+-8). Inputs
//                outside the range clamp to the end entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module activation_sigmoid #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] result
);

    localparam int c_depth = 256;

    // exp() by range reduction: Taylor series on y/256, then squared 8 times
    function automatic real exp_approx(input real y);
        real t;
        real s;
        real term;
        t    = y / 256.0;
        s    = 1.0;
        term = 1.0;
        for (int k = 1; k <= 10; k++) begin
            term = term * t / $itor(k);
            s    = s + term;
        end
        for (int k = 0; k < 8; k++) begin
            s = s * s;
        end
        return s;
    endfunction

    // Rounded table entry for bin i, evaluated only at elaboration
    function automatic logic [WIDTH-1:0] lut_entry(input int i);
        real x;
        real sig;
        x   = -8.0 + 16.0 * $itor(i) / 255.0;
        sig = 1.0 / (1.0 + exp_approx(-x));
        return WIDTH'($rtoi(sig * (2.0 ** FRAC_BITS) + 0.5));
    endfunction

    logic [WIDTH-1:0]        w_lut [c_depth];
    logic signed [WIDTH:0]   w_ofs;
    logic [7:0]              w_idx;

    for (genvar i = 0; i < c_depth; i++) begin : g_lut
        localparam logic [WIDTH-1:0] c_entry = lut_entry(i);
        assign w_lut[i] = c_entry;
    end

    // Shift the input so -8.0 maps to zero, then take 4 integer + 4
    // fractional bits as the bin index; clamp outside [-8, 8)
    always_comb begin
        w_ofs = $signed({operand[WIDTH-1], operand})
              + $signed((WIDTH+1)'(64'd8 << FRAC_BITS));
        if (w_ofs < 0) begin
            w_idx = 8'd0;
        end else if (w_ofs >= $signed((WIDTH+1)'(64'd16 << FRAC_BITS))) begin
            w_idx = 8'd255;
        end else begin
            w_idx = w_ofs[FRAC_BITS+3 -: 8];
        end
        result = w_lut[w_idx];
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. The search for the next grant starts
//                one lane past the most recently granted lane; the pointer
//                only moves when the caller reports a completed handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import act_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0] r_last_grant;
    logic            w_found;

    // Pointer to the last lane that completed a handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else if (advance) begin
            r_last_grant <= grant_idx;
        end
    end

    // First requesting lane at or after last_grant+1, wrapping modulo NUM_REQ
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!w_found && req[(int'(r_last_grant) + off) % NUM_REQ]) begin
                w_found   = 1'b1;
                grant_idx = ID_W'((int'(r_last_grant) + off) % NUM_REQ);
                grant[(int'(r_last_grant) + off) % NUM_REQ] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/activation_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : activation_arbiter
//  Description : Shares one activation_sigmoid lookup among NUM_REQ
//                valid/ready requesters with round-robin arbitration and a
//                single registered, backpressured response stage tagged with
//                the requester index.
//                Optional build macro ACT_ARB_STATS_EN adds saturating stall
//                and per-lane grant counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module activation_arbiter
    import act_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 32,
    parameter  int FRAC_BITS = 16,
    localparam int ID_W      = clog2_min1(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       busy
`ifdef ACT_ARB_STATS_EN
    ,
    output logic [ACT_STAT_W-1:0]          stall_cnt,
    output logic [NUM_REQ*ACT_STAT_W-1:0]  grant_cnt
`endif
);

    out_state_e          r_state;
    out_state_e          w_next_state;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_grant_idx;
    logic                w_can_accept;
    logic                w_accept;
    logic [WIDTH-1:0]    w_operand;
    logic [WIDTH-1:0]    w_lut_result;
    logic [WIDTH-1:0]    r_rsp_data;
    logic [ID_W-1:0]     r_rsp_id;

    // Readiness is suppressed during reset so no handshake can slip through
    // in the reset cycle
    always_comb begin
        w_can_accept = !rst && ((r_state == ST_EMPTY) || rsp_ready);
        req_ready    = w_grant & {NUM_REQ{w_can_accept}};
        w_accept     = |(req_valid & req_ready);
        w_operand    = req_data[int'(w_grant_idx)*WIDTH +: WIDTH];
        busy         = rsp_valid || (|req_valid);
    end

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (w_accept),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    activation_sigmoid #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_activation_sigmoid (
        .operand   (w_operand),
        .result    (w_lut_result)
    );

    // Output-stage state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Output-stage next state: fill on accept, drain when consumed and not refilled
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_next_state = ST_FULL;
            ST_FULL:  if (!w_accept && rsp_ready) w_next_state = ST_EMPTY;
            default:  w_next_state = ST_EMPTY;
        endcase
    end

    // Output-stage outputs
    always_comb begin
        rsp_valid = (r_state == ST_FULL);
        rsp_data  = r_rsp_data;
        rsp_id    = r_rsp_id;
    end

    // Result and tag capture on every accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
        end else if (w_accept) begin
            r_rsp_data <= w_lut_result;
            r_rsp_id   <= w_grant_idx;
        end
    end

`ifdef ACT_ARB_STATS_EN
    logic [ACT_STAT_W-1:0] r_stall_cnt;

    // Saturating count of cycles where a result waits on downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (rsp_valid && !rsp_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
        logic [ACT_STAT_W-1:0] r_cnt;

        // Saturating count of handshakes on this lane
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (req_valid[g] && req_ready[g] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign grant_cnt[g*ACT_STAT_W +: ACT_STAT_W] = r_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: doc/activation_arbiter.md
Name: activation_arbiter

Overview:
Shares one activation_sigmoid lookup instance among NUM_REQ requesters, such as parallel neuron/PE lanes. Uses round-robin arbitration and valid/ready handshakes on each request port. The granted operand is looked up and held in a single registered response stage that supports backpressure. Each result is tagged with the requester ID, and the block sits between PE accumulator outputs and the layer writeback path.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 32, operand/result width; Q(WIDTH-FRAC_BITS).FRAC_BITS signed in, unsigned out
FRAC_BITS, 16, fractional bits, passed to the LUT instance
ID_W, $clog2(NUM_REQ), localparam, response tag width

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_data  in  NUM_REQ*WIDTH  packed operands, lane i at [i*WIDTH +: WIDTH]
rsp_valid  out  1  result valid
rsp_ready  in  1  downstream accept
rsp_data  out  WIDTH  sigmoid result
rsp_id  out  ID_W  index of requester that produced rsp_data
busy  out  1  high while rsp_valid is high or any req_valid is high

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0. Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- Output-stage FSM, two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - EMPTY→FULL on an accept.
  - FULL→EMPTY when rsp_ready=1 and there is no accept.
  - FULL stays FULL when rsp_ready=1 with an accept (result replaced), or when rsp_ready=0 (held).
- can_accept = (state==EMPTY) | rsp_ready.
- Arbitration, combinational:
  - Search starts at last_grant+1 mod NUM_REQ.
  - The first lane with req_valid set gets grant.
  - req_ready = grant & {NUM_REQ{can_accept}}.
  - A handshake on lane i is req_valid[i] & req_ready[i].
- req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready. Once asserted, req_valid and its data hold until the handshake.
- On a handshake: the LUT result of the granted lane's data is registered into rsp_data, i into rsp_id, and last_grant is set to i.
- With no handshake, last_grant is unchanged.
- Latency: handshake in cycle N gives rsp_valid in cycle N+1. Throughput is 1 result/cycle when rsp_ready is held high.
- While rsp_valid=1 and rsp_ready=0: rsp_data and rsp_id are stable and req_ready is all-zero.
- Fairness: with all lanes continuously valid and rsp_ready=1, grants rotate 0,1,..,NUM_REQ-1,0. No lane waits more than NUM_REQ-1 grants.
- Single active lane: granted every cycle.
- Reset mid-operation: the pending result is discarded. rsp_valid is 0 in the cycle after the rst edge, and no req_ready is asserted in the reset cycle.
- LUT mapping, clamping and saturation are owned by the activation_sigmoid instance. No extra arithmetic is added here.

Optional Feature:
ACT_ARB_STATS_EN
- Defined:
  - Adds output stall_cnt [31:0]: counts cycles with rsp_valid & ~rsp_ready.
  - Adds output grant_cnt [NUM_REQ*32-1:0]: per-lane handshake counters.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package act_pkg:
  - Function clog2_min1: returns at least 1, so ID_W is valid for any NUM_REQ.
  - Typedef for the output-state enum {ST_EMPTY, ST_FULL}.
  - Constant ACT_STAT_W = 32.
- Sub-module rr_arbiter (NUM_REQ): inputs req, advance, rst; outputs grant (one-hot) and grant_idx; owns last_grant.
- activation_arbiter instantiates rr_arbiter and activation_sigmoid; only the output register and FSM are local.

Test Plan:
- Reset, idle, then lane 0 sends data 0 with rsp_ready=1 → rsp_valid next cycle, rsp_data=33282, rsp_id=0.
- All 4 lanes valid continuously, rsp_ready=1, 8 cycles → rsp_id sequence 0,1,2,3,0,1,2,3, one result per cycle.
- Lane 2 sends 32'h7FFF_FFFF, lane 3 sends 32'h8000_0000 → results 65514 (id 2) then 22 (id 3).
- rsp_valid=1 with rsp_ready=0 for 5 cycles → rsp_data/rsp_id unchanged and req_ready=0. rsp_ready=1 → drains, and the next grant goes to the lane after the last granted.
- rst asserted for 1 cycle while FULL with requests pending → rsp_valid=0 next cycle, then lane 0 is granted first.
- With ACT_ARB_STATS_EN defined: 3 stall cycles plus 4 grants on lane 1 → stall_cnt=3, lane 1 grant_cnt=4, other lanes 0.
